futurefpga_cfg_loader: RTL

Configuration loader that sits directly upstream of the `futurefpga_slice` array. It receives a byte-wide bitstream over a valid/ready handshake and assembles one 20-bit CFG word per slice in a shadow bank. It validates an XOR checksum and commits all words atomically to the slices' CFG inputs. It also holds the slices in reset until a valid configuration has been committed.

---
 rtl/futurefpga_cfg_pkg.sv | 22 ++
 rtl/futurefpga_cfg_shadow.sv | 41 ++++
 rtl/futurefpga_cfg_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/futurefpga_cfg_pkg.sv
// rtl/futurefpga_cfg_pkg.sv - shared constants, CFG field map and FSM states for the cfg loader
package futurefpga_cfg_pkg;

  localparam int CFG_W = 20;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // CFG word field positions inside one slice word
  localparam int CFG_INIT_LSB  = 0;
  localparam int CFG_INIT_MSB  = 15;
  localparam int CFG_FF_USED   = 16;
  localparam int CFG_FF_ISEL   = 17;
  localparam int CFG_CARRY_EN  = 18;
  localparam int CFG_CIN_CONST = 19;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/futurefpga_cfg_shadow.sv
// rtl/futurefpga_cfg_shadow.sv - shadow bank assembling one CFG word per slice from stream bytes
module futurefpga_cfg_shadow
  import futurefpga_cfg_pkg::*;
#(
  parameter int NUM_SLICES  = 16,
  parameter int SLICE_IDX_W = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [SLICE_IDX_W-1:0]      i_slice_idx,
  input  logic [1:0]                  i_byte_idx,
  input  logic [7:0]                  i_data,
  output logic [NUM_SLICES*CFG_W-1:0] o_flat
);

  logic [CFG_W-1:0] r_bank [NUM_SLICES];

  // Byte-lane writes; the third byte only carries the four flag bits, its upper nibble is dropped
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_SLICES; k++) begin
        r_bank[k] <= '0;
      end
    end else if (i_wr_en) begin
      case (i_byte_idx)
        2'd0: r_bank[i_slice_idx][CFG_INIT_LSB +: 8] <= i_data;
        2'd1: r_bank[i_slice_idx][CFG_INIT_MSB -: 8] <= i_data;
        2'd2: r_bank[i_slice_idx][CFG_CIN_CONST:CFG_FF_USED] <=
                {i_data[CFG_CIN_CONST - CFG_FF_USED], i_data[CFG_CARRY_EN - CFG_FF_USED],
                 i_data[CFG_FF_ISEL - CFG_FF_USED], i_data[0]};
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_flat
    assign o_flat[k*CFG_W +: CFG_W] = r_bank[k];
  end

endmodule

// File: rtl/futurefpga_cfg_loader.sv
// rtl/futurefpga_cfg_loader.sv - byte-stream config loader with XOR check and atomic commit to slices
module futurefpga_cfg_loader #(
  parameter int NUM_SLICES = 16,
  parameter int CFG_W      = 20
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [7:0]                  IN_DATA,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  output logic [NUM_SLICES*CFG_W-1:0] CFG_OUT,
  output logic                        SLICE_RST,
  output logic                        CFG_VALID,
  output logic                        CFG_DONE,
  output logic                        CFG_ERR
);

  import futurefpga_cfg_pkg::*;

  localparam int NBYTES = NUM_SLICES * 3;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam int SW     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  cfg_state_e                  r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [SW-1:0]               r_slice;
  logic [1:0]                  r_byte;
  logic [7:0]                  r_xor;
  logic                        r_fmt_err;
  logic [NUM_SLICES*CFG_W-1:0] r_cfg_out;
  logic                        r_slice_rst;
  logic                        r_cfg_valid;
  logic                        r_cfg_done;
  logic                        r_cfg_err;

  logic                        w_accept;
  logic                        w_last;
  logic                        w_shadow_wr;
  logic [NUM_SLICES*CFG_W-1:0] w_shadow_flat;

  // Ready is the only combinational output; it is held low through reset and the commit cycle
  assign IN_READY    = ~RST & (r_state != COMMIT);
  assign w_accept    = IN_VALID & IN_READY;
  assign w_last      = (r_cnt == CNT_W'(NBYTES - 1));
  assign w_shadow_wr = w_accept & (r_state == LOAD);

  assign CFG_OUT   = r_cfg_out;
  assign SLICE_RST = r_slice_rst;
  assign CFG_VALID = r_cfg_valid;
  assign CFG_DONE  = r_cfg_done;
  assign CFG_ERR   = r_cfg_err;

  futurefpga_cfg_shadow #(
    .NUM_SLICES  (NUM_SLICES),
    .SLICE_IDX_W (SW)
  ) u_shadow (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_wr_en     (w_shadow_wr),
    .i_slice_idx (r_slice),
    .i_byte_idx  (r_byte),
    .i_data      (IN_DATA),
    .o_flat      (w_shadow_flat)
  );

  // Frame FSM: sync hunt, payload load with running XOR, checksum verdict, one-cycle commit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_slice     <= '0;
      r_byte      <= '0;
      r_xor       <= '0;
      r_fmt_err   <= 1'b0;
      r_cfg_out   <= '0;
      r_slice_rst <= 1'b1;
      r_cfg_valid <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && IN_DATA == SYNC_BYTE) begin
            r_cfg_err <= 1'b0;
            r_xor     <= '0;
            r_cnt     <= '0;
            r_slice   <= '0;
            r_byte    <= '0;
            r_fmt_err <= 1'b0;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_xor <= r_xor ^ IN_DATA;
            if (r_byte == 2'd2 && IN_DATA[7:4] != 4'h0) begin
              r_fmt_err <= 1'b1;
            end
            if (w_last) begin
              r_state <= CHECK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if (r_byte == 2'd2) begin
                r_byte  <= 2'd0;
                r_slice <= r_slice + 1'b1;
              end else begin
                r_byte <= r_byte + 1'b1;
              end
            end
          end
        end
        CHECK: begin
          if (w_accept) begin
            if (IN_DATA == r_xor && !r_fmt_err) begin
              r_state <= COMMIT;
            end else begin
              r_cfg_err <= 1'b1;
              r_state   <= IDLE;
            end
          end
        end
        COMMIT: begin
          r_cfg_out   <= w_shadow_flat;
          r_cfg_done  <= 1'b1;
          r_cfg_valid <= 1'b1;
          r_slice_rst <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
